ezusb_stream_arb: RTL and testbench

- Round-robin scheduler that shares the single FPGA->host stream of the EZ-USB interface among NCH independent source channels.
- Each grant is framed: the block emits a header word identifying the channel, then forwards that channel's data words.
- A burst ends either on the channel's end-of-packet word or after BURST_MAX data words.
- On end-of-packet the block drives the interface's manual PKTEND arm and waits for PKTEND before re-arbitrating.

---
 rtl/ezusb_stream_arb.sv | 161 ++++++++++++++++
 tb/tb_ezusb_stream_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ezusb_stream_arb.sv
// Round-robin arbiter that frames NCH source streams onto the single EZ-USB FPGA->host stream.
// Each grant emits a header word and then channel data, and ends with a manual PKTEND flush on end-of-packet.
module ezusb_stream_arb #(
    parameter int         NCH           = 4,
    parameter int         BURST_MAX     = 256,
    parameter logic [7:0] HDR_MAGIC     = 8'hA5,
    parameter int         FLUSH_TIMEOUT = 4096
) (
    input  logic              ifclk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [16*NCH-1:0] ch_data,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_last,
    output logic [NCH-1:0]    ch_ready,
    output logic [15:0]       DI,
    output logic              DI_valid,
    input  logic              DI_ready,
    output logic              DI_enable,
    output logic              pktend_arm,
    input  logic              PKTEND,
    output logic [2:0]        cur_ch,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  rr_ptr, rr_ptr_nxt, cur_ch_nxt;
    logic [15:0] word_cnt, word_cnt_nxt;
    logic [15:0] flush_cnt, flush_cnt_nxt;
    logic        err_nxt;

    // Channel inputs padded to 8 lanes so a 3-bit channel number indexes them directly.
    logic [15:0] data_arr [8];
    logic [7:0]  valid_arr;
    logic [7:0]  last_arr;
    logic [7:0]  ready_arr;

    logic [3:0]  cand;
    logic [2:0]  pick;
    logic        pick_ok;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        if (i < NCH) begin : g_ch
            assign data_arr[i]  = ch_data[16*i +: 16];
            assign valid_arr[i] = ch_valid[i];
            assign last_arr[i]  = ch_last[i];
        end else begin : g_unused
            assign data_arr[i]  = '0;
            assign valid_arr[i] = 1'b0;
            assign last_arr[i]  = 1'b0;
        end
    end

    assign ch_ready = ready_arr[NCH-1:0];
    assign busy     = (state != IDLE);

    // Search upward from the channel after the last grant, so the last winner has lowest priority.
    always_comb begin
        cand    = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = 4'(rr_ptr) + 4'(k);
            if (cand >= 4'(NCH)) begin
                cand = cand - 4'(NCH);
            end
            if (!pick_ok && valid_arr[cand[2:0]]) begin
                pick    = cand[2:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        cur_ch_nxt    = cur_ch;
        word_cnt_nxt  = word_cnt;
        flush_cnt_nxt = flush_cnt;
        err_nxt       = err_timeout;
        DI            = '0;
        DI_valid      = 1'b0;
        pktend_arm    = 1'b0;
        ready_arr     = '0;

        case (state)
            IDLE: begin
                if (en && pick_ok) begin
                    cur_ch_nxt   = pick;
                    rr_ptr_nxt   = pick;
                    word_cnt_nxt = '0;
                    state_nxt    = HDR;
                end
            end

            HDR: begin
                DI       = {HDR_MAGIC, 5'd0, cur_ch};
                DI_valid = 1'b1;
                if (DI_ready) begin
                    state_nxt = DATA;
                end
            end

            DATA: begin
                DI                = data_arr[cur_ch];
                DI_valid          = valid_arr[cur_ch];
                ready_arr[cur_ch] = DI_ready;
                if (valid_arr[cur_ch] && DI_ready) begin
                    word_cnt_nxt = word_cnt + 16'd1;
                    // End-of-packet wins over the burst limit so the packet still gets its PKTEND.
                    if (last_arr[cur_ch]) begin
                        state_nxt = FLUSH;
                    end else if (({1'b0, word_cnt} + 17'd1) == 17'(BURST_MAX)) begin
                        state_nxt = IDLE;
                    end
                end
            end

            FLUSH: begin
                pktend_arm    = 1'b1;
                flush_cnt_nxt = flush_cnt + 16'd1;
                if (!PKTEND) begin
                    flush_cnt_nxt = '0;
                    state_nxt     = IDLE;
                end else if (flush_cnt == 16'(FLUSH_TIMEOUT - 1)) begin
                    err_nxt       = 1'b1;
                    flush_cnt_nxt = '0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= 3'(NCH - 1);
            cur_ch      <= '0;
            word_cnt    <= '0;
            flush_cnt   <= '0;
            err_timeout <= 1'b0;
            DI_enable   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cur_ch      <= cur_ch_nxt;
            word_cnt    <= word_cnt_nxt;
            flush_cnt   <= flush_cnt_nxt;
            err_timeout <= err_nxt;
            DI_enable   <= (en && (|ch_valid)) || (state != IDLE);
        end
    end

endmodule

// File: tb/tb_ezusb_stream_arb.sv
// Randomized bench for ezusb_stream_arb: per-channel packet queues feed the DUT and a
// transaction-level model predicts every framed word, handshake and flush outcome each cycle.
module tb_ezusb_stream_arb;

    localparam int NCH  = 4;
    localparam int BM   = 4;
    localparam int FT   = 16;
    localparam int NCYC = 4000;
    localparam int QD   = 4096;

    logic              ifclk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic [16*NCH-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_last = '0;
    logic [NCH-1:0]    ch_ready;
    logic [15:0]       DI;
    logic              DI_valid;
    logic              DI_ready = 1'b0;
    logic              DI_enable;
    logic              pktend_arm;
    logic              PKTEND = 1'b1;
    logic [2:0]        cur_ch;
    logic              busy;
    logic              err_timeout;

    always #5 ifclk = ~ifclk;

    ezusb_stream_arb #(
        .NCH(NCH), .BURST_MAX(BM), .HDR_MAGIC(8'hA5), .FLUSH_TIMEOUT(FT)
    ) dut (
        .ifclk(ifclk), .reset_n(reset_n), .en(en),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_last(ch_last), .ch_ready(ch_ready),
        .DI(DI), .DI_valid(DI_valid), .DI_ready(DI_ready), .DI_enable(DI_enable),
        .pktend_arm(pktend_arm), .PKTEND(PKTEND),
        .cur_ch(cur_ch), .busy(busy), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source side: one packet queue per channel, {last, data} per entry.
    logic [16:0] sq [NCH][QD];
    int          hd [NCH];
    int          tl [NCH];

    // Reference model of the grant currently in progress.
    bit          m_busy, m_hdr, m_flush, m_err, m_die;
    logic [1:0]  m_ch, m_rr;
    int          m_words, m_fc;

    task automatic push_pkt(input int ch, input int len);
        for (int j = 0; j < len; j++) begin
            sq[ch][tl[ch] % QD] = {(j == len - 1), 16'($urandom)};
            tl[ch]++;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_hdr = 0; m_flush = 0; m_err = 0; m_die = 0;
        m_ch = 2'd0; m_rr = 2'(NCH - 1); m_words = 0; m_fc = 0;
    endtask

    task automatic drive(input int cyc);
        bit          directed;
        logic [16:0] w;
        directed = (cyc < 60);
        en       = directed ? 1'b1 : ($urandom % 8 != 0);
        DI_ready = directed ? 1'b1 : ($urandom % 4 != 0);
        PKTEND   = (cyc >= 2000 && cyc < 2300) ? 1'b1 : ($urandom % 6 != 0);
        for (int i = 0; i < NCH; i++) begin
            if (!directed && hd[i] == tl[i] && $urandom % 4 == 0) begin
                push_pkt(i, 1 + int'($urandom % 10));
            end
            w = sq[i][hd[i] % QD];
            if (hd[i] != tl[i]) begin
                ch_valid[i]         = directed ? 1'b1 : ($urandom % 4 != 0);
                ch_data[16*i +: 16] = w[15:0];
                ch_last[i]          = w[16];
            end else begin
                ch_valid[i]         = 1'b0;
                ch_data[16*i +: 16] = 16'($urandom);
                ch_last[i]          = 1'($urandom);
            end
        end
    endtask

    task automatic check_outputs();
        logic [15:0]    exp_di;
        logic           exp_v;
        logic [NCH-1:0] exp_rdy;
        logic [16:0]    head;
        exp_di  = '0;
        exp_v   = 1'b0;
        exp_rdy = '0;
        head    = sq[m_ch][hd[m_ch] % QD];
        if (m_busy && m_hdr) begin
            exp_v  = 1'b1;
            exp_di = {8'hA5, 5'd0, 1'b0, m_ch};
        end else if (m_busy && !m_flush) begin
            exp_v   = ch_valid[m_ch];
            exp_di  = head[15:0];
            exp_rdy = DI_ready ? (4'b0001 << m_ch) : 4'b0000;
        end
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("DI_valid", 32'(DI_valid), 32'(exp_v));
        if (exp_v || !m_busy) check_eq("DI", 32'(DI), 32'(exp_di));
        check_eq("ch_ready", 32'(ch_ready), 32'(exp_rdy));
        check_eq("pktend_arm", 32'(pktend_arm), 32'(m_busy && m_flush));
        if (m_busy) check_eq("cur_ch", 32'(cur_ch), {30'd0, m_ch});
        check_eq("err_timeout", 32'(err_timeout), 32'(m_err));
        check_eq("DI_enable", 32'(DI_enable), 32'(m_die));
    endtask

    task automatic step_model();
        bit          was_busy, anyv, found;
        logic [16:0] head;
        logic [1:0]  ci;
        was_busy = m_busy;
        anyv     = |ch_valid;
        found    = 0;
        if (!m_busy) begin
            if (en && anyv) begin
                for (int k = 1; k <= NCH; k++) begin
                    ci = 2'((int'(m_rr) + k) % NCH);
                    if (!found && ch_valid[ci]) begin
                        found = 1;
                        m_ch  = ci;
                    end
                end
                m_rr = m_ch; m_busy = 1; m_hdr = 1; m_words = 0;
            end
        end else if (m_hdr) begin
            if (DI_ready) m_hdr = 0;
        end else if (m_flush) begin
            if (!PKTEND) begin
                m_busy = 0; m_flush = 0; m_fc = 0;
            end else if (m_fc == FT - 1) begin
                m_err = 1; m_busy = 0; m_flush = 0; m_fc = 0;
            end else begin
                m_fc++;
            end
        end else if (ch_valid[m_ch] && DI_ready) begin
            head = sq[m_ch][hd[m_ch] % QD];
            hd[m_ch]++;
            m_words++;
            if (head[16]) begin
                m_flush = 1; m_fc = 0;
            end else if (m_words == BM) begin
                m_busy = 0;
            end
        end
        m_die = (en && anyv) || was_busy;
    endtask

    initial begin
        bit did_mid;
        bit rst_now;
        did_mid = 0;
        for (int i = 0; i < NCH; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        // Opening packet on channel 1: three words, last on the third.
        sq[1][0] = {1'b0, 16'h1111};
        sq[1][1] = {1'b0, 16'h2222};
        sq[1][2] = {1'b1, 16'h3333};
        tl[1]    = 3;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge ifclk);
            rst_now = (cyc < 3) || (cyc == 2900) ||
                      (cyc > 600 && !did_mid && m_busy && !m_hdr && !m_flush && m_words == 2);
            if (rst_now) begin
                if (cyc >= 3 && cyc != 2900) did_mid = 1;
                reset_n = 1'b0;
                #1;
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_DI_valid", 32'(DI_valid), 32'd0);
                check_eq("rst_DI", 32'(DI), 32'd0);
                check_eq("rst_pktend_arm", 32'(pktend_arm), 32'd0);
                check_eq("rst_ch_ready", 32'(ch_ready), 32'd0);
                check_eq("rst_DI_enable", 32'(DI_enable), 32'd0);
                check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
                check_eq("rst_cur_ch", 32'(cur_ch), 32'd0);
                model_reset();
            end else begin
                reset_n = 1'b1;
                drive(cyc);
                #1;
                check_outputs();
                step_model();
            end
        end
        if (!did_mid) check_eq("mid_burst_reset_reached", 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
